tmr_fault_monitor: RTL and testbench
====================================

# tmr_fault_monitor

Downstream consumer of the 1-bit triple voter's `disagreement` and `fault_flags` outputs. Per lane (A/B/C), it accumulates fault statistics and declares a lane failed after a run of consecutive faults. It also detects inconsistent voter status and summarises TMR health in a 4-state FSM with an interrupt pulse. Software or a supervisor clears it through a req/ack handshake.

## Interface
Parameters:
- `CNT_W`, 8: width of each per-lane saturating fault counter.
- `PERSIST`, 4: consecutive fault samples that declare a lane failed. Legal range 1..255.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: reset. Synchronous and active-high.
- `disagreement`, in, 1: registered voter disagreement flag.
- `fault_flags`, in, 3: registered voter flags. [2]=A, [1]=B, [0]=C.
- `clr_req`, in, 1: clear request level, held until `clr_ack`.
- `clr_ack`, out, 1: one-cycle clear acknowledge.
- `err_cnt`, out, 3*CNT_W: saturating fault-cycle counts. [3*CNT_W-1:2*CNT_W]=A, then B, then C.
- `lane_failed`, out, 3: sticky per-lane failed flags, same bit order as `fault_flags`.
- `voter_error`, out, 1: sticky flag for inconsistent voter status.
- `health`, out, 2: FSM state.
- `irq`, out, 1: one-cycle event pulse.

## Operation
- All inputs are sampled every `clk` edge. There is no valid qualifier, because the voter output is valid every cycle after reset.
- Per lane i, on a normal sample:
  - `fault_flags[i]`=1: `err_cnt[i]` increments, saturating at 2^CNT_W-1. The run counter increments, saturating at PERSIST.
  - `fault_flags[i]`=0: the run counter clears to 0.
  - When the run counter reaches PERSIST, `lane_failed[i]` sets. It stays set until clear or reset.
- `voter_error` sets, sticky, when either holds:
  - more than one `fault_flags` bit is set;
  - `disagreement` differs from the OR of `fault_flags`.
- The sample that sets `voter_error` still updates the counters normally.
- `health` FSM uses encodings NOMINAL=0, TRANSIENT=1, DEGRADED=2, LOST=3. It is computed from next-cycle register values:
  - LOST: 2 or more `lane_failed` bits set.
  - DEGRADED: exactly 1 `lane_failed` bit set.
  - TRANSIENT: no lane failed, and some run counter is nonzero.
  - NOMINAL: none of the above.
  - DEGRADED and LOST are left only by clear or reset. TRANSIENT returns to NOMINAL once all run counters are 0.
- `irq` pulses for one cycle on the edge where any of these occur:
  - any `lane_failed` bit rises;
  - `voter_error` rises;
  - `health` enters LOST.
- Multiple events on the same edge produce a single pulse.
- Clear handshake:
  - A clear executes on the first edge where `clr_req`=1 and the internal armed flag is set.
  - That edge zeroes all counters, run counters, `lane_failed` and `voter_error`. It sets `health`=NOMINAL, drives `clr_ack`=1 for one cycle, and disarms.
  - The monitor re-arms when `clr_req` is sampled 0.
  - Holding `clr_req` high therefore yields exactly one clear.

## Timing
- Reset, synchronous and active-high, sets:
  - all outputs, counters and run counters to 0;
  - `health`=NOMINAL;
  - the armed flag to 1.
- `rst` has priority over everything.
- Latency:
  - Outputs are registered.
  - A fault sampled at edge k appears in `err_cnt` after edge k.
  - `lane_failed[i]` is visible after the edge that captures the PERSIST-th consecutive fault sample.
  - `irq` is asserted in that same cycle.
- Simultaneous clear and fault: the clear wins. That edge's input sample is discarded, and no `irq` is raised.
- With PERSIST=1, a single fault sample fails the lane.
- A fault sample on an already-failed lane increments `err_cnt` only. No new `irq` is raised.
- `err_cnt` saturates and never wraps.

## Structure
- Shared package `tmr_pkg` holds:
  - `health` state encodings (HEALTH_NOMINAL/TRANSIENT/DEGRADED/LOST);
  - lane index constants (LANE_A=2, LANE_B=1, LANE_C=0).
- Sub-module `tmr_lane_counter` is instantiated 3×. It contains:
  - the saturating `err_cnt`;
  - the run counter, with width `$clog2(PERSIST+1)`;
  - the sticky failed flag.
- The top level holds the consistency check, FSM, irq edge detect and clear handshake.

## Test plan
All scenarios use CNT_W=8 and PERSIST=4.
- Reset, then all inputs 0 for 10 cycles: all outputs 0, `health`=0, `irq` never asserted.
- `fault_flags`=3'b100 with `disagreement`=1 for 3 cycles, then 0:
  - `err_cnt` A=3;
  - `health` goes 1 then back to 0;
  - `lane_failed`=0, no `irq`.
- 3'b100 for 4 cycles:
  - `lane_failed`=3'b100 and `irq`=1 after the 4th edge;
  - `health`=2.
- Then 3'b001 for 4 cycles: `lane_failed`=3'b101, `health`=3, exactly one `irq`.
- 300 cycles of 3'b010: `err_cnt` B saturates at 255.
- Inconsistent samples each set `voter_error` and pulse `irq` once:
  - `fault_flags`=3'b110;
  - `disagreement`=1 with `fault_flags`=0.
- `clr_req` held high 5 cycles while `fault_flags`=3'b100:
  - a single `clr_ack` pulse;
  - everything zeroed on the ack edge;
  - later faults count from 0;
  - a second clear only after `clr_req` drops for at least 1 cycle.
- `rst` asserted mid-run at `health`=3: all outputs 0 on the next edge.

Source files
------------

// File: rtl/tmr_pkg.sv
// Shared constants for the TMR fault monitor: health encodings and lane indices.
package tmr_pkg;

  localparam int unsigned NUM_LANES = 3;

  // Lane positions inside fault_flags / lane_failed / err_cnt.
  localparam int unsigned LANE_A = 2;
  localparam int unsigned LANE_B = 1;
  localparam int unsigned LANE_C = 0;

  // Health FSM encodings, visible on the health output.
  localparam logic [1:0] HEALTH_NOMINAL   = 2'd0;
  localparam logic [1:0] HEALTH_TRANSIENT = 2'd1;
  localparam logic [1:0] HEALTH_DEGRADED  = 2'd2;
  localparam logic [1:0] HEALTH_LOST      = 2'd3;

endpackage : tmr_pkg

// File: rtl/tmr_lane_counter.sv
// Per-lane fault statistics: saturating fault count, consecutive-fault run
// counter and sticky failed flag.
//   clk, rst       : clock, synchronous active-high reset
//   fault          : voter fault flag for this lane
//   clr            : clear; wins over the current sample
//   err_cnt        : saturating count of fault samples (registered)
//   failed         : sticky lane-failed flag (registered)
//   failed_nxt_c   : value failed takes on the next edge (combinational)
//   run_nz_nxt_c   : run counter nonzero after the next edge (combinational)
module tmr_lane_counter
  import tmr_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PERSIST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fault,
  input  logic             clr,
  output logic [CNT_W-1:0] err_cnt,
  output logic             failed,
  output logic             failed_nxt_c,
  output logic             run_nz_nxt_c
);

  localparam int unsigned       RUN_W   = $clog2(PERSIST + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(PERSIST);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [RUN_W-1:0] run_q;
  logic [RUN_W-1:0] run_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // Next-state for counters and sticky flag.
  always_comb begin
    run_nxt      = run_q;
    cnt_nxt      = err_cnt;
    failed_nxt_c = failed;
    if (clr) begin
      run_nxt      = '0;
      cnt_nxt      = '0;
      failed_nxt_c = 1'b0;
    end else begin
      if (fault) begin
        if (err_cnt != CNT_MAX) cnt_nxt = err_cnt + CNT_W'(1);
        if (run_q != RUN_MAX)   run_nxt = run_q + RUN_W'(1);
      end else begin
        run_nxt = '0;
      end
      // run_nxt can only equal PERSIST on a fault sample since PERSIST >= 1.
      if (run_nxt == RUN_MAX) failed_nxt_c = 1'b1;
    end
    run_nz_nxt_c = (run_nxt != '0);
  end

  // Lane state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      run_q   <= '0;
      err_cnt <= '0;
      failed  <= 1'b0;
    end else begin
      run_q   <= run_nxt;
      err_cnt <= cnt_nxt;
      failed  <= failed_nxt_c;
    end
  end

endmodule : tmr_lane_counter

// File: rtl/tmr_fault_monitor.sv
// Monitors triple-voter status: per-lane fault statistics, voter consistency
// check, TMR health FSM, event interrupt and a req/ack clear handshake.
//   clk, rst      : clock, synchronous active-high reset
//   disagreement  : voter disagreement flag
//   fault_flags   : voter per-lane fault flags, [2]=A [1]=B [0]=C
//   clr_req       : clear request level, held until clr_ack
//   clr_ack       : one-cycle clear acknowledge
//   err_cnt       : saturating per-lane fault counts, A in the top slice
//   lane_failed   : sticky per-lane failed flags
//   voter_error   : sticky inconsistent-voter-status flag
//   health        : health FSM state
//   irq           : one-cycle event pulse
module tmr_fault_monitor
  import tmr_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PERSIST = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        disagreement,
  input  logic [NUM_LANES-1:0]        fault_flags,
  input  logic                        clr_req,
  output logic                        clr_ack,
  output logic [NUM_LANES*CNT_W-1:0]  err_cnt,
  output logic [NUM_LANES-1:0]        lane_failed,
  output logic                        voter_error,
  output logic [1:0]                  health,
  output logic                        irq
);

  logic                 armed;
  logic                 clr_fire_c;
  logic [NUM_LANES-1:0] failed_nxt_c;
  logic [NUM_LANES-1:0] run_nz_nxt_c;
  logic [1:0]           nfail_nxt_c;
  logic                 inconsistent_c;
  logic                 verr_nxt_c;
  logic [1:0]           health_nxt_c;
  logic                 irq_nxt_c;

  assign clr_fire_c = clr_req & armed;

  // Per-lane counters.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    tmr_lane_counter #(
      .CNT_W   (CNT_W),
      .PERSIST (PERSIST)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .fault        (fault_flags[i]),
      .clr          (clr_fire_c),
      .err_cnt      (err_cnt[i*CNT_W +: CNT_W]),
      .failed       (lane_failed[i]),
      .failed_nxt_c (failed_nxt_c[i]),
      .run_nz_nxt_c (run_nz_nxt_c[i])
    );
  end

  // Consistency check, health next-state and interrupt events.
  always_comb begin
    nfail_nxt_c    = 2'(failed_nxt_c[2]) + 2'(failed_nxt_c[1]) + 2'(failed_nxt_c[0]);
    inconsistent_c = (fault_flags[2] & fault_flags[1]) |
                     (fault_flags[2] & fault_flags[0]) |
                     (fault_flags[1] & fault_flags[0]) |
                     (disagreement != (|fault_flags));
    verr_nxt_c     = clr_fire_c ? 1'b0 : (voter_error | inconsistent_c);

    health_nxt_c = health;
    case (health)
      HEALTH_NOMINAL, HEALTH_TRANSIENT: begin
        if (nfail_nxt_c >= 2'd2)      health_nxt_c = HEALTH_LOST;
        else if (nfail_nxt_c == 2'd1) health_nxt_c = HEALTH_DEGRADED;
        else if (|run_nz_nxt_c)       health_nxt_c = HEALTH_TRANSIENT;
        else                          health_nxt_c = HEALTH_NOMINAL;
      end
      HEALTH_DEGRADED: begin
        if (nfail_nxt_c >= 2'd2) health_nxt_c = HEALTH_LOST;
      end
      HEALTH_LOST: health_nxt_c = HEALTH_LOST;
      default:     health_nxt_c = HEALTH_NOMINAL;
    endcase
    if (clr_fire_c) health_nxt_c = HEALTH_NOMINAL;

    irq_nxt_c = ~clr_fire_c &
                ((|(failed_nxt_c & ~lane_failed)) |
                 (verr_nxt_c & ~voter_error) |
                 ((health_nxt_c == HEALTH_LOST) && (health != HEALTH_LOST)));
  end

  // State register, status flags and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      health      <= HEALTH_NOMINAL;
      voter_error <= 1'b0;
      irq         <= 1'b0;
      clr_ack     <= 1'b0;
      armed       <= 1'b1;
    end else begin
      health      <= health_nxt_c;
      voter_error <= verr_nxt_c;
      irq         <= irq_nxt_c;
      clr_ack     <= clr_fire_c;
      // Disarm on a clear; re-arm only once clr_req has been seen low.
      if (clr_fire_c)    armed <= 1'b0;
      else if (!clr_req) armed <= 1'b1;
    end
  end

endmodule : tmr_fault_monitor

// File: tb/tb_tmr_fault_monitor.sv
// Self-checking bench for tmr_fault_monitor: directed scenarios followed by
// random stimulus, all compared against a behavioural model of the monitor.
module tb_tmr_fault_monitor;
  import tmr_pkg::*;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned PERSIST = 4;
  localparam int          CMAX    = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        disagreement;
  logic [2:0]  fault_flags;
  logic        clr_req;
  logic        clr_ack;
  logic [23:0] err_cnt;
  logic [2:0]  lane_failed;
  logic        voter_error;
  logic [1:0]  health;
  logic        irq;

  tmr_fault_monitor #(.CNT_W(CNT_W), .PERSIST(PERSIST)) dut (
    .clk          (clk),
    .rst          (rst),
    .disagreement (disagreement),
    .fault_flags  (fault_flags),
    .clr_req      (clr_req),
    .clr_ack      (clr_ack),
    .err_cnt      (err_cnt),
    .lane_failed  (lane_failed),
    .voter_error  (voter_error),
    .health       (health),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int irq_seen = 0;
  int ack_seen = 0;

  // Behavioural model state.
  int m_cnt[3];
  int m_run[3];
  bit m_fail[3];
  bit m_verr, m_irq, m_ack, m_armed;
  int m_health;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int classify();
    int nf = 0;
    bit any_run = 0;
    for (int i = 0; i < 3; i++) begin
      nf += int'(m_fail[i]);
      if (m_run[i] > 0) any_run = 1;
    end
    if (nf >= 2) return 3;
    if (nf == 1) return 2;
    if (any_run) return 1;
    return 0;
  endfunction

  task automatic model_step(input logic [2:0] ff, input logic dis, input logic cr, input logic r);
    bit rise;
    int prev_h;
    int ones;
    if (r) begin
      for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_run[i] = 0; m_fail[i] = 0; end
      m_verr = 0; m_irq = 0; m_ack = 0; m_armed = 1; m_health = 0;
    end else if (cr && m_armed) begin
      for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_run[i] = 0; m_fail[i] = 0; end
      m_verr = 0; m_irq = 0; m_ack = 1; m_armed = 0; m_health = 0;
    end else begin
      rise = 0;
      prev_h = m_health;
      for (int i = 0; i < 3; i++) begin
        if (ff[i]) begin
          m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
          m_run[i] = (m_run[i] < PERSIST) ? m_run[i] + 1 : PERSIST;
        end else begin
          m_run[i] = 0;
        end
        if (m_run[i] == PERSIST && !m_fail[i]) begin
          m_fail[i] = 1;
          rise = 1;
        end
      end
      ones = int'(ff[0]) + int'(ff[1]) + int'(ff[2]);
      if ((ones > 1 || dis != (ones > 0)) && !m_verr) begin
        m_verr = 1;
        rise = 1;
      end
      // Degraded/lost are sticky through sticky lane_failed bits.
      m_health = classify();
      if (m_health == 3 && prev_h != 3) rise = 1;
      m_irq = rise;
      m_ack = 0;
      if (!cr) m_armed = 1;
    end
  endtask

  task automatic step(input logic [2:0] ff, input logic dis, input logic cr, input logic r);
    @(negedge clk);
    fault_flags  = ff;
    disagreement = dis;
    clr_req      = cr;
    rst          = r;
    model_step(ff, dis, cr, r);
    @(posedge clk);
    #1;
    check("err_cnt", 32'(err_cnt),
          32'((m_cnt[2] << 16) | (m_cnt[1] << 8) | m_cnt[0]));
    check("lane_failed", 32'(lane_failed), {29'd0, m_fail[2], m_fail[1], m_fail[0]});
    check("voter_error", 32'(voter_error), 32'(m_verr));
    check("health", 32'(health), 32'(m_health));
    check("irq", 32'(irq), 32'(m_irq));
    check("clr_ack", 32'(clr_ack), 32'(m_ack));
    if (irq) irq_seen++;
    if (clr_ack) ack_seen++;
  endtask

  // Consistent sample: disagreement mirrors any lane fault.
  task automatic samp(input logic [2:0] ff, input int n);
    for (int k = 0; k < n; k++) step(ff, |ff, 1'b0, 1'b0);
  endtask

  initial begin
    int irq0, ack0;
    logic [2:0] ff;
    logic dis, cr, r;
    fault_flags = '0; disagreement = 0; clr_req = 0; rst = 1;

    step(3'b000, 0, 0, 1);
    check("rst_health", 32'(health), 32'(HEALTH_NOMINAL));

    // Idle.
    irq0 = irq_seen;
    samp(3'b000, 10);
    check("idle_irq", 32'(irq_seen - irq0), 0);

    // Transient on lane A.
    samp(3'b100, 3);
    check("trans_health", 32'(health), 32'(HEALTH_TRANSIENT));
    samp(3'b000, 1);
    check("trans_cntA", 32'(err_cnt[23:16]), 3);
    check("trans_back", 32'(health), 32'(HEALTH_NOMINAL));

    // Lane A fails.
    irq0 = irq_seen;
    samp(3'b100, 4);
    check("a_fail", 32'(lane_failed), 32'(3'b100));
    check("a_irq", 32'(irq), 1);
    check("a_degraded", 32'(health), 32'(HEALTH_DEGRADED));

    // Lane C fails -> lost, exactly one pulse.
    irq0 = irq_seen;
    samp(3'b001, 4);
    check("c_fail", 32'(lane_failed), 32'(3'b101));
    check("lost", 32'(health), 32'(HEALTH_LOST));
    check("lost_irq_cnt", 32'(irq_seen - irq0), 1);

    // Lane B saturation.
    samp(3'b010, 300);
    check("b_sat", 32'(err_cnt[15:8]), 255);

    // Two faults at once.
    step(3'b110, 1, 0, 0);
    check("multi_verr", 32'(voter_error), 1);
    check("multi_irq", 32'(irq), 1);
    step(3'b000, 0, 1, 0);
    step(3'b000, 0, 0, 0);
    // Disagreement without any fault.
    step(3'b000, 1, 0, 0);
    check("dis_verr", 32'(voter_error), 1);
    check("dis_irq", 32'(irq), 1);

    // Held clear while faulting: one ack, then counting restarts.
    step(3'b000, 0, 0, 0);
    ack0 = ack_seen;
    step(3'b100, 1, 1, 0);
    check("clr_zero", 32'(err_cnt), 0);
    for (int k = 0; k < 4; k++) step(3'b100, 1, 1, 0);
    check("clr_once", 32'(ack_seen - ack0), 1);
    check("clr_recount", 32'(err_cnt[23:16]), 4);
    step(3'b000, 0, 0, 0);
    step(3'b000, 0, 1, 0);
    check("clr_second", 32'(clr_ack), 1);
    step(3'b000, 0, 0, 0);

    // Reach LOST then reset.
    samp(3'b100, 4);
    samp(3'b001, 4);
    check("lost2", 32'(health), 32'(HEALTH_LOST));
    step(3'b010, 1, 0, 1);
    check("rst_mid", 32'(health), 32'(HEALTH_NOMINAL));

    // Random traffic.
    cr = 0;
    for (int k = 0; k < 2000; k++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: ff = 3'b000;
        4, 5, 6, 7: begin ff = 3'b000; ff[$urandom_range(0, 2)] = 1'b1; end
        default:    ff = 3'($urandom_range(0, 7));
      endcase
      dis = |ff;
      if ($urandom_range(0, 19) == 0) dis = ~dis;
      if ($urandom_range(0, 15) == 0) cr = ~cr;
      r = ($urandom_range(0, 299) == 0);
      step(ff, dis, cr, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_tmr_fault_monitor
